// File: rtl/conv1_win_ctrl.sv
// rtl/conv1_win_ctrl.sv - raster-scan 5x5 window controller for conv1 (optional err output: CONV1_WIN_ERR_EN)
module conv1_win_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pixel_valid,
    output logic       win_valid,
    output logic [4:0] out_row,
    output logic [4:0] out_col,
    output logic       busy,
`ifdef CONV1_WIN_ERR_EN
    output logic       err,
`endif
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Five-bit counters cover images up to 32x32; the last index is 31.
    localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
    localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);
    localparam logic [4:0] KM1      = 5'(K - 1);

    state_t     state;
    logic [4:0] in_row;
    logic [4:0] in_col;

    // Frame FSM: raster counters, registered window strobe/coordinates, busy and frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_row     <= 5'd0;
            in_col     <= 5'd0;
            win_valid  <= 1'b0;
            out_row    <= 5'd0;
            out_col    <= 5'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        in_row <= 5'd0;
                        in_col <= 5'd0;
                    end
                end
                RUN: begin
                    if (pixel_valid) begin
                        // A window closes on every pixel whose bottom-right corner is in range.
                        if (in_row >= KM1 && in_col >= KM1) begin
                            win_valid <= 1'b1;
                            out_row   <= in_row - KM1;
                            out_col   <= in_col - KM1;
                        end
                        if (in_col == LAST_COL) begin
                            in_col <= 5'd0;
                            if (in_row == LAST_ROW) begin
                                state <= DONE;
                            end else begin
                                in_row <= in_row + 5'd1;
                            end
                        end else begin
                            in_col <= in_col + 5'd1;
                        end
                    end
                end
                DONE: begin
                    // Last window strobe is out this cycle; frame_done follows it.
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV1_WIN_ERR_EN
    // Sticky protocol error: start during a frame, or pixels with no frame open.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                    end else if (pixel_valid) begin
                        err <= 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    err <= err;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/conv1_win_ctrl.md
CONV1_WIN_CTRL -- requirements
Module: conv1_win_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, meaning input image height in pixels.
REQ-003 SHALL have parameter K, default 5, meaning square kernel size.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-007 SHALL have port pixel_valid  input  1  one raster-order pixel accepted into the line buffer this cycle.
REQ-008 SHALL have port win_valid  output  1  5x5 window complete; drives valid_in of the conv1 5x5 calc.
REQ-009 SHALL have port out_row  output  5  output feature-map row, 0..IMG_H-K.
REQ-010 SHALL have port out_col  output  5  output feature-map column, 0..IMG_W-K.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last window.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 -> RUN next cycle; in_row/in_col counters cleared to 0.
REQ-015 RUN: each pixel_valid=1 cycle advances in_col; at in_col=IMG_W-1 it wraps to 0 and in_row increments.
REQ-016 RUN: pixel_valid=0 cycles hold all counters (stall) with no bound on length.
REQ-017 win_valid SHALL be registered: high exactly one cycle after a pixel_valid at in_row>=K-1 and in_col>=K-1, low otherwise.
REQ-018 out_row/out_col SHALL be registered alongside win_valid as in_row-(K-1), in_col-(K-1); they hold their value while win_valid=0.
REQ-019 A frame SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1) win_valid pulses (576 at defaults), row-major, no gaps in coordinate sequence.
REQ-020 pixel_valid at (IMG_H-1, IMG_W-1) -> DONE next cycle; DONE lasts one cycle, asserts frame_done, then -> IDLE.
REQ-021 frame_done SHALL coincide with the cycle after the last win_valid pulse (latency 2 cycles from last pixel).
REQ-022 busy SHALL be high in RUN and DONE, low in IDLE.
REQ-023 start in RUN or DONE SHALL be ignored; start in the same cycle as the DONE->IDLE transition is ignored.
REQ-024 pixel_valid in IDLE or DONE SHALL be ignored and SHALL NOT move counters.
REQ-025 Counters SHALL be wide enough for IMG_W, IMG_H up to 32; no other wrap-around occurs.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, counters 0, win_valid=0, out_row=0, out_col=0, busy=0, frame_done=0, err=0 next cycle, including mid-frame.
REQ-027 After reset release, a new start SHALL be required before any win_valid.

Configuration
REQ-028 With CONV1_WIN_ERR_EN defined, SHALL add output err (1 bit), sticky, set by start in RUN or pixel_valid in IDLE; cleared only by reset or by an accepted start in IDLE.
REQ-029 Without CONV1_WIN_ERR_EN, port err SHALL not exist and those events are silently ignored per REQ-023/024.

Verification
REQ-030 Reset then start, 784 consecutive pixel_valid -> 576 win_valid, first with (0,0) one cycle after pixel 4*28+4=116, last (23,23), frame_done 2 cycles after pixel 783.
REQ-031 Same frame with pixel_valid toggled 1/0 every cycle -> identical coordinate sequence, 576 pulses, no win_valid on stall cycles' outputs beyond one per pixel.
REQ-032 rst_n=0 for one cycle after 300 pixels -> all outputs 0, busy=0; 784 pixels without start -> no win_valid.
REQ-033 start pulsed at pixel 100 of a frame -> frame unaffected, 576 windows; with CONV1_WIN_ERR_EN err=1 until next accepted start.
REQ-034 Parameters IMG_W=8, IMG_H=6, K=5 -> 8 windows, coordinates (0,0)..(1,3), frame_done after 48th pixel +2 cycles.
